// File: rtl/opc6_bus_arbiter.sv
// Round-robin arbiter that shares one memory/IO bus between two opc6 cores by gating their clken inputs.
// Optional bus-cycle timeout with a sticky error flag is enabled by defining OPC6ARB_TIMEOUT_EN.
module opc6_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        cpu0_vpa,
  input  logic        cpu0_vda,
  input  logic        cpu0_vio,
  input  logic [15:0] cpu0_address,
  input  logic [15:0] cpu0_dout,
  input  logic        cpu0_rnw,
  output logic        cpu0_clken,
  input  logic        cpu1_vpa,
  input  logic        cpu1_vda,
  input  logic        cpu1_vio,
  input  logic [15:0] cpu1_address,
  input  logic [15:0] cpu1_dout,
  input  logic        cpu1_rnw,
  output logic        cpu1_clken,
  output logic [15:0] cpu_din,
  output logic        mem_vpa,
  output logic        mem_vda,
  output logic        mem_vio,
  output logic [15:0] mem_address,
  output logic [15:0] mem_dout,
  output logic        mem_rnw,
  input  logic [15:0] mem_din,
  input  logic        mem_ready,
  output logic [1:0]  gnt,
  output logic        bus_err
);

  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;
  localparam logic [1:0] ST_BUS0 = 2'd2;
  localparam logic [1:0] ST_BUS1 = 2'd3;

  logic [1:0] state_reg, state_next;
  logic [1:0] rcnt_reg, rcnt_next;
  logic       last_reg, last_next;
  logic       req0, req1;
  logic       in_bus;
  logic       tmo;
  logic       done;

  assign req0   = cpu0_vpa | cpu0_vda | cpu0_vio;
  assign req1   = cpu1_vpa | cpu1_vda | cpu1_vio;
  assign in_bus = state_reg[1];

`ifdef OPC6ARB_TIMEOUT_EN
  logic [7:0] tcnt_reg;
  logic       bus_err_reg;

  // Forced completion once the access has waited TIMEOUT bus cycles without ready.
  assign tmo     = in_bus && !mem_ready && (tcnt_reg == 8'(TIMEOUT - 1));
  assign bus_err = bus_err_reg;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      tcnt_reg    <= 8'd0;
      bus_err_reg <= 1'b0;
    end else begin
      if (!in_bus)
        tcnt_reg <= 8'd0;
      else if (!mem_ready)
        tcnt_reg <= tcnt_reg + 8'd1;
      if (tmo)
        bus_err_reg <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign tmo            = 1'b0;
  assign bus_err        = 1'b0;
`endif

  assign done    = in_bus && (mem_ready || tmo);
  assign cpu_din = tmo ? 16'hFFFF : mem_din;

  always_comb begin
    state_next  = state_reg;
    rcnt_next   = rcnt_reg;
    last_next   = last_reg;
    cpu0_clken  = 1'b1;
    cpu1_clken  = 1'b1;
    gnt         = 2'b00;
    mem_vpa     = 1'b0;
    mem_vda     = 1'b0;
    mem_vio     = 1'b0;
    mem_address = 16'h0000;
    mem_dout    = 16'h0000;
    mem_rnw     = 1'b1;
    case (state_reg)
      ST_RST: begin
        if (rcnt_reg == 2'd2)
          state_next = ST_ARB;
        else
          rcnt_next = rcnt_reg + 2'd1;
      end
      ST_ARB: begin
        cpu0_clken = !req0;
        cpu1_clken = !req1;
        // On contention the core that did not win last time gets the bus.
        if (req0 && req1)
          state_next = last_reg ? ST_BUS0 : ST_BUS1;
        else if (req0)
          state_next = ST_BUS0;
        else if (req1)
          state_next = ST_BUS1;
      end
      ST_BUS0: begin
        gnt         = 2'b01;
        mem_vpa     = cpu0_vpa;
        mem_vda     = cpu0_vda;
        mem_vio     = cpu0_vio;
        mem_address = cpu0_address;
        mem_dout    = cpu0_dout;
        mem_rnw     = cpu0_rnw;
        cpu0_clken  = done;
        cpu1_clken  = !req1;
        if (done) begin
          last_next  = 1'b0;
          state_next = ST_ARB;
        end
      end
      default: begin
        gnt         = 2'b10;
        mem_vpa     = cpu1_vpa;
        mem_vda     = cpu1_vda;
        mem_vio     = cpu1_vio;
        mem_address = cpu1_address;
        mem_dout    = cpu1_dout;
        mem_rnw     = cpu1_rnw;
        cpu1_clken  = done;
        cpu0_clken  = !req0;
        if (done) begin
          last_next  = 1'b1;
          state_next = ST_ARB;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_reg <= ST_RST;
      rcnt_reg  <= 2'd0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      rcnt_reg  <= rcnt_next;
      last_reg  <= last_next;
    end
  end

endmodule

// File: tb/tb_opc6_bus_arbiter.sv
// Scoreboard bench for opc6_bus_arbiter: the stimulus process queues hand-computed per-cycle
// expectations, and a monitor pops and compares them at each falling edge.
module tb_opc6_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        cpu0_vpa, cpu0_vda, cpu0_vio, cpu0_rnw, cpu0_clken;
  logic [15:0] cpu0_address, cpu0_dout;
  logic        cpu1_vpa, cpu1_vda, cpu1_vio, cpu1_rnw, cpu1_clken;
  logic [15:0] cpu1_address, cpu1_dout;
  logic [15:0] cpu_din;
  logic        mem_vpa, mem_vda, mem_vio, mem_rnw, mem_ready;
  logic [15:0] mem_address, mem_dout, mem_din;
  logic [1:0]  gnt;
  logic        bus_err;

  typedef struct {
    string       name;
    logic [56:0] bits;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic exp_err  = 1'b0;

  always #5 clk = ~clk;

  opc6_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_b(reset_b),
    .cpu0_vpa(cpu0_vpa), .cpu0_vda(cpu0_vda), .cpu0_vio(cpu0_vio),
    .cpu0_address(cpu0_address), .cpu0_dout(cpu0_dout), .cpu0_rnw(cpu0_rnw),
    .cpu0_clken(cpu0_clken),
    .cpu1_vpa(cpu1_vpa), .cpu1_vda(cpu1_vda), .cpu1_vio(cpu1_vio),
    .cpu1_address(cpu1_address), .cpu1_dout(cpu1_dout), .cpu1_rnw(cpu1_rnw),
    .cpu1_clken(cpu1_clken),
    .cpu_din(cpu_din),
    .mem_vpa(mem_vpa), .mem_vda(mem_vda), .mem_vio(mem_vio),
    .mem_address(mem_address), .mem_dout(mem_dout), .mem_rnw(mem_rnw),
    .mem_din(mem_din), .mem_ready(mem_ready),
    .gnt(gnt), .bus_err(bus_err)
  );

  // Packed view: gnt, clken0, clken1, {vpa,vda,vio}, rnw, address, dout, cpu_din, bus_err.
  task automatic E(input string nm, input logic [1:0] g, input logic ck0, input logic ck1,
                   input logic [2:0] st, input logic rnw, input logic [15:0] addr,
                   input logic [15:0] dout, input logic [15:0] din);
    exp_t e;
    e.name = nm;
    e.bits = {g, ck0, ck1, st, rnw, addr, dout, din, exp_err};
    sb.push_back(e);
  endtask

  task automatic E_idle(input string nm, input logic ck0, input logic ck1, input logic [15:0] din);
    E(nm, 2'b00, ck0, ck1, 3'b000, 1'b1, 16'h0000, 16'h0000, din);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t        e;
    logic [56:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {gnt, cpu0_clken, cpu1_clken, mem_vpa, mem_vda, mem_vio, mem_rnw,
               mem_address, mem_dout, cpu_din, bus_err};
        checks++;
        if (act !== e.bits) begin
          failures++;
          $display("FAIL %s actual=%h required=%h", e.name, act, e.bits);
        end else begin
          $display("ok   %s value=%h", e.name, act);
        end
      end
    end
  end

  initial begin
    reset_b = 1'b0;
    cpu0_vpa = 1'b0; cpu0_vda = 1'b1; cpu0_vio = 1'b0; cpu0_rnw = 1'b1;
    cpu0_address = 16'h0010; cpu0_dout = 16'h1111;
    cpu1_vpa = 1'b0; cpu1_vda = 1'b1; cpu1_vio = 1'b0; cpu1_rnw = 1'b1;
    cpu1_address = 16'h0020; cpu1_dout = 16'h2222;
    mem_ready = 1'b1;
    mem_din   = 16'hBEEF;

    step(); E_idle("rst_hold", 1'b1, 1'b1, 16'hBEEF);
    step(); reset_b = 1'b1; E_idle("rst_cyc0", 1'b1, 1'b1, 16'hBEEF);
    step(); E_idle("rst_cyc1", 1'b1, 1'b1, 16'hBEEF);
    step(); E_idle("rst_cyc2", 1'b1, 1'b1, 16'hBEEF);
    step(); E_idle("first_arb", 1'b0, 1'b0, 16'hBEEF);

    // Contention with zero wait states: 01,00,10,00,01
    step(); E("cont_bus0_a", 2'b01, 1'b1, 1'b0, 3'b010, 1'b1, 16'h0010, 16'h1111, 16'hBEEF);
    step(); E_idle("cont_arb_a", 1'b0, 1'b0, 16'hBEEF);
    step(); E("cont_bus1", 2'b10, 1'b0, 1'b1, 3'b010, 1'b1, 16'h0020, 16'h2222, 16'hBEEF);
    step(); E_idle("cont_arb_b", 1'b0, 1'b0, 16'hBEEF);
    step(); E("cont_bus0_b", 2'b01, 1'b1, 1'b0, 3'b010, 1'b1, 16'h0010, 16'h1111, 16'hBEEF);

    // Wait states; mem_ready low during ARB must not matter
    step(); cpu1_vda = 1'b0; cpu0_address = 16'h0100; mem_ready = 1'b0;
    E_idle("ws_arb_ready_ignored", 1'b0, 1'b1, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      step(); E($sformatf("ws_wait%0d", i), 2'b01, 1'b0, 1'b1, 3'b010, 1'b1, 16'h0100, 16'h1111, 16'hBEEF);
    end
    step(); mem_ready = 1'b1; mem_din = 16'h5A5A;
    E("ws_done", 2'b01, 1'b1, 1'b1, 3'b010, 1'b1, 16'h0100, 16'h1111, 16'h5A5A);

    // Idle peer: core 0 served every two cycles via vpa
    step(); cpu0_vpa = 1'b1; cpu0_vda = 1'b0; cpu0_address = 16'h0300;
    E_idle("idle_arb_a", 1'b0, 1'b1, 16'h5A5A);
    step(); E("idle_bus0_a", 2'b01, 1'b1, 1'b1, 3'b100, 1'b1, 16'h0300, 16'h1111, 16'h5A5A);
    step(); E_idle("idle_arb_b", 1'b0, 1'b1, 16'h5A5A);
    step(); E("idle_bus0_b", 2'b01, 1'b1, 1'b1, 3'b100, 1'b1, 16'h0300, 16'h1111, 16'h5A5A);

    // Write from core 1 on an IO cycle; mem side stays idle outside BUS1
    step(); cpu0_vpa = 1'b0; cpu1_vio = 1'b1; cpu1_rnw = 1'b0;
    cpu1_address = 16'h1234; cpu1_dout = 16'hA5A5;
    E_idle("wr_arb", 1'b1, 1'b0, 16'h5A5A);
    step(); E("wr_bus1", 2'b10, 1'b1, 1'b1, 3'b001, 1'b0, 16'h1234, 16'hA5A5, 16'h5A5A);
    step(); cpu1_vio = 1'b0;
    E_idle("wr_arb_after", 1'b1, 1'b1, 16'h5A5A);
    step(); E_idle("no_req_arb", 1'b1, 1'b1, 16'h5A5A);

`ifdef OPC6ARB_TIMEOUT_EN
    step(); cpu0_vda = 1'b1; cpu0_address = 16'h0200; mem_ready = 1'b0;
    E_idle("to_arb", 1'b0, 1'b1, 16'h5A5A);
    for (int i = 0; i < 3; i++) begin
      step(); E($sformatf("to_wait%0d", i), 2'b01, 1'b0, 1'b1, 3'b010, 1'b1, 16'h0200, 16'h1111, 16'h5A5A);
    end
    step(); E("to_done", 2'b01, 1'b1, 1'b1, 3'b010, 1'b1, 16'h0200, 16'h1111, 16'hFFFF);
    step(); cpu0_vda = 1'b0; exp_err = 1'b1;
    E_idle("to_err_sticky", 1'b1, 1'b1, 16'h5A5A);
`endif

    // Reset asserted mid-access: grant drops at once, no completion pulse
    step(); cpu0_vda = 1'b1; cpu0_address = 16'h0400; mem_ready = 1'b0;
    E_idle("mid_arb", 1'b0, 1'b1, 16'h5A5A);
    step(); E("mid_bus0", 2'b01, 1'b0, 1'b1, 3'b010, 1'b1, 16'h0400, 16'h1111, 16'h5A5A);
    step(); reset_b = 1'b0; exp_err = 1'b0;
    E_idle("mid_reset", 1'b1, 1'b1, 16'h5A5A);
    step(); E_idle("reset_held", 1'b1, 1'b1, 16'h5A5A);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
